// File: rtl/mem_responder_pkg.sv
// Shared constants and FSM encoding for mem_responder.
// Requester tags, field widths and service states.
package mem_responder_pkg;

  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_DC   = 2'd1;
  localparam logic [1:0] ID_IC   = 2'd2;

  localparam int ID_W   = 2;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_req_fifo.sv
// Request FIFO: WIDTH-bit entries, DEPTH (power of two) deep.
// Ports: clock, rst, push/wdata, pop/rdata (show-ahead), full, empty, count.
module mem_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mem_responder.sv
// Queued word-memory responder with fixed wait states.
// Ports: clock, rst, mem_* request/response bus with tagged read data.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clock,
  input  logic        rst,
  output logic        mem_waitrequest,
  input  logic [1:0]  mem_id,
  input  logic [29:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_writedata,
  input  logic [3:0]  mem_writedatamask,
  output logic [31:0] mem_readdata,
  output logic [1:0]  mem_readdataid
);

  localparam int ENT_W = ID_W + ADDR_W + 1 + DATA_W + MASK_W;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  logic             push, pop;
  logic             empty, full_unused;
  logic [CW-1:0]    count;
  logic [ENT_W-1:0] push_data, head;
  logic             unused_addr;

  // Upper address bits are deliberately dropped: addresses wrap.
  assign unused_addr = ^mem_address[29:ADDR_W];

  assign mem_waitrequest = (count == CW'(FIFO_DEPTH));
  assign push = (mem_read | mem_write) & ~mem_waitrequest;
  // A simultaneous read+write is queued as a write only.
  assign push_data = {mem_id, mem_address[ADDR_W-1:0], mem_write,
                      mem_writedata, mem_writedatamask};

  mem_req_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (head),
    .full  (full_unused),
    .empty (empty),
    .count (count)
  );

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ENT_W-1:0] cur_q, cur_d;
  logic [1:0]       rdid_q, rdid_d;
  logic [31:0]      rdata_q;

  logic [1:0]        cur_id;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_wr;
  logic [31:0]       cur_data;
  logic [3:0]        cur_mask;
  logic              ram_we, ram_re;

  assign {cur_id, cur_addr, cur_wr, cur_data, cur_mask} = cur_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    rdid_d  = ID_NONE;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_ACCESS;
          pop     = 1'b1;
          cur_d   = head;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
        else             state_d = S_DONE;
      end
      S_DONE: begin
        if (!cur_wr) rdid_d = cur_id;
        // Back-to-back service skips IDLE.
        if (!empty) begin
          state_d = S_ACCESS;
          pop     = 1'b1;
          cur_d   = head;
          cnt_d   = 4'(WAIT_STATES);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      rdid_q  <= ID_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      rdid_q  <= rdid_d;
    end
  end

  // Reset forces IDLE asynchronously, so no write can land under rst.
  assign ram_we = (state_q == S_DONE) & cur_wr & ~rst;
  assign ram_re = (state_q == S_DONE) & ~cur_wr;

  logic [31:0] ram [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_mask[b]) ram[cur_addr][8*b +: 8] <= cur_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst)         rdata_q <= '0;
    else if (ram_re) rdata_q <= ram[cur_addr];
  end

  assign mem_readdata   = rdata_q;
  assign mem_readdataid = rdid_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder.
// Schedule-based reference model plus directed and random traffic.
module tb_mem_responder;

  localparam int AW = 12;
  localparam int WS = 2;
  localparam int FD = 4;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic        mem_waitrequest;
  logic [1:0]  mem_id = '0;
  logic [29:0] mem_address = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_writedata = '0;
  logic [3:0]  mem_writedatamask = '0;
  logic [31:0] mem_readdata;
  logic [1:0]  mem_readdataid;

  always #5 clock = ~clock;

  mem_responder #(
    .ADDR_W      (AW),
    .WAIT_STATES (WS),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clock             (clock),
    .rst               (rst),
    .mem_waitrequest   (mem_waitrequest),
    .mem_id            (mem_id),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_writedatamask (mem_writedatamask),
    .mem_readdata      (mem_readdata),
    .mem_readdataid    (mem_readdataid)
  );

  typedef struct {
    longint          done;
    logic            wr;
    logic [1:0]      id;
    logic [AW-1:0]   addr;
    logic [31:0]     data;
    logic [3:0]      mask;
  } req_t;

  req_t        pend[$];
  longint      t = 0;
  longint      last_pop = -100;
  logic [31:0] mem_m [1<<AW];
  logic [31:0] last_rd = '0;
  int          checks = 0;
  int          errors = 0;
  int          nresp = 0;
  longint      last_resp_t = 0;
  logic [31:0] last_resp_data = '0;
  logic        wait_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Queue occupancy: accepted requests whose pop edge is still ahead.
  function automatic logic model_wait();
    int n = 0;
    foreach (pend[i]) if (pend[i].done - WS - 2 > t) n++;
    return (n == FD);
  endfunction

  task automatic step(input logic rd, input logic wr,
                      input logic [1:0] id, input logic [29:0] a,
                      input logic [31:0] d, input logic [3:0] m,
                      output logic acc);
    req_t       e;
    logic [1:0] eid;
    longint     p;
    @(negedge clock);
    mem_read = rd;
    mem_write = wr;
    mem_id = id;
    mem_address = a;
    mem_writedata = d;
    mem_writedatamask = m;
    acc = (rd | wr) && !model_wait();
    @(posedge clock);
    t++;
    if (acc) begin
      p = (last_pop + WS + 2 > t + 1) ? last_pop + WS + 2 : t + 1;
      last_pop = p;
      e.done = p + WS + 2;
      e.wr = wr;
      e.id = id;
      e.addr = a[AW-1:0];
      e.data = d;
      e.mask = m;
      pend.push_back(e);
    end
    eid = 2'd0;
    while (pend.size() > 0 && pend[0].done == t) begin
      e = pend.pop_front();
      if (e.wr) begin
        for (int b = 0; b < 4; b++)
          if (e.mask[b]) mem_m[e.addr][8*b +: 8] = e.data[8*b +: 8];
      end else begin
        eid = e.id;
        last_rd = mem_m[e.addr];
      end
    end
    #1;
    chk("readdataid", {30'd0, mem_readdataid}, {30'd0, eid});
    chk("readdata", mem_readdata, last_rd);
    chk("waitrequest", {31'd0, mem_waitrequest}, {31'd0, model_wait()});
    if (mem_waitrequest === 1'b1) wait_seen = 1'b1;
    if (mem_readdataid !== 2'd0) begin
      nresp++;
      last_resp_t = t;
      last_resp_data = mem_readdata;
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, acc);
  endtask

  task automatic send(input logic rd, input logic wr,
                      input logic [1:0] id, input logic [29:0] a,
                      input logic [31:0] d, input logic [3:0] m);
    logic acc = 1'b0;
    int   n = 0;
    while (!acc && n < 50) begin
      step(rd, wr, id, a, d, m, acc);
      n++;
    end
    chk("accept_bound", {31'd0, acc}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    mem_read = 0;
    mem_write = 0;
    mem_id = 0;
    #2 rst = 1'b1;
    pend.delete();
    last_pop = -100;
    last_rd = '0;
    #1;
    chk("rst_readdataid", {30'd0, mem_readdataid}, 32'd0);
    chk("rst_readdata", mem_readdata, 32'd0);
    chk("rst_waitrequest", {31'd0, mem_waitrequest}, 32'd0);
    @(posedge clock);
    t++;
    @(negedge clock);
    rst = 1'b0;
  endtask

  initial begin
    longint t0;
    int     n0;
    logic   acc;
    int     r;
    logic [29:0] a;

    do_reset();

    for (int i = 0; i < 16; i++) send(0, 1, 0, 30'(i), 32'd0, 4'hF);
    idle(40);

    // Write then read, same address.
    send(0, 1, 1, 30'd5, 32'h12345678, 4'hF);
    t0 = t;
    n0 = nresp;
    send(1, 0, 1, 30'd5, 32'd0, 4'h0);
    idle(20);
    chk("s1_latency", 32'(last_resp_t - t0), 32'd9);
    chk("s1_data", last_resp_data, 32'h12345678);
    chk("s1_count", 32'(nresp - n0), 32'd1);

    // Byte-masked write.
    send(0, 1, 1, 30'd7, 32'hAABBCCDD, 4'h5);
    send(1, 0, 2, 30'd7, 32'd0, 4'h0);
    idle(20);
    chk("s2_data", last_resp_data, 32'h00BB00DD);

    // Six back-to-back reads.
    wait_seen = 1'b0;
    n0 = nresp;
    for (int i = 0; i < 6; i++)
      send(1, 0, (i % 2 == 0) ? 2'd1 : 2'd2, 30'(i), 32'd0, 4'h0);
    idle(40);
    chk("s3_wait_seen", {31'd0, wait_seen}, 32'd1);
    chk("s3_count", 32'(nresp - n0), 32'd6);

    // Address wrap.
    send(0, 1, 1, 30'h1003, 32'hCAFEF00D, 4'hF);
    send(1, 0, 1, 30'h0003, 32'd0, 4'h0);
    idle(20);
    chk("s4_wrap", last_resp_data, 32'hCAFEF00D);

    // Read+write together acts as a write.
    n0 = nresp;
    send(1, 1, 1, 30'd9, 32'h55, 4'hF);
    idle(20);
    chk("s5_noresp", 32'(nresp - n0), 32'd0);
    send(1, 0, 2, 30'd9, 32'd0, 4'h0);
    idle(20);
    chk("s5_data", last_resp_data, 32'h55);

    // Reset mid-operation.
    send(1, 0, 1, 30'd1, 32'd0, 4'h0);
    send(1, 0, 2, 30'd2, 32'd0, 4'h0);
    send(1, 0, 1, 30'd3, 32'd0, 4'h0);
    n0 = nresp;
    do_reset();
    idle(20);
    chk("s6_noresp", 32'(nresp - n0), 32'd0);
    send(1, 0, 1, 30'd5, 32'd0, 4'h0);
    t0 = t;
    idle(20);
    chk("s6_latency", 32'(last_resp_t - t0), 32'(WS + 3));
    chk("s6_data", last_resp_data, 32'h12345678);

    // Random traffic over 16 low addresses with random upper bits.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 3);
      a = 30'($urandom);
      a[AW-1:4] = '0;
      step(r == 1 || r == 3, r >= 2, 2'($urandom_range(0, 2)), a,
           $urandom, 4'($urandom), acc);
    end
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
